// File: rtl/painterengine_gpu_video_pkg.sv
// painterengine_gpu_video_pkg
// Shared types for the video timing generator: the four-phase enum used by
// both axes, the 12-bit coordinate type, default 640x480@60 timing and the
// colour-bar lookup used by the optional test pattern.
package painterengine_gpu_video_pkg;

    localparam int COORD_W         = 12;
    localparam int COORD_MAX_TOTAL = 4096;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_t;

    // 640x480@60 defaults.
    localparam int   DEF_H_ACTIVE  = 640;
    localparam int   DEF_H_FP      = 16;
    localparam int   DEF_H_SYNC    = 96;
    localparam int   DEF_H_BP      = 48;
    localparam int   DEF_V_ACTIVE  = 480;
    localparam int   DEF_V_FP      = 10;
    localparam int   DEF_V_SYNC    = 2;
    localparam int   DEF_V_BP      = 33;
    localparam logic DEF_HSYNC_POL = 1'b0;
    localparam logic DEF_VSYNC_POL = 1'b0;

    // Eight vertical bars, left to right.
    function automatic logic [23:0] bar_colour(input logic [2:0] bar);
        logic [23:0] colour;
        case (bar)
            3'd0:    colour = 24'hFFFFFF;  // white
            3'd1:    colour = 24'hFFFF00;  // yellow
            3'd2:    colour = 24'h00FFFF;  // cyan
            3'd3:    colour = 24'h00FF00;  // green
            3'd4:    colour = 24'hFF00FF;  // magenta
            3'd5:    colour = 24'hFF0000;  // red
            3'd6:    colour = 24'h0000FF;  // blue
            3'd7:    colour = 24'h000000;  // black
            default: colour = 24'h000000;
        endcase
        return colour;
    endfunction

endpackage

// File: rtl/painterengine_gpu_timing_axis.sv
// painterengine_gpu_timing_axis
// One timing axis: a position counter 0..TOTAL-1 plus a phase FSM walking
// ACTIVE -> FRONT -> SYNC -> BACK. Moves one step per cycle with advance=1;
// clear returns it to position 0 / ACTIVE and wins over advance. wrap flags
// the step that leaves the last BACK position.
module painterengine_gpu_timing_axis
    import painterengine_gpu_video_pkg::*;
#(
    parameter int ACTIVE_LEN = DEF_H_ACTIVE,
    parameter int FRONT_LEN  = DEF_H_FP,
    parameter int SYNC_LEN   = DEF_H_SYNC,
    parameter int BACK_LEN   = DEF_H_BP
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   clear,
    input  logic   advance,
    output coord_t count,
    output phase_t phase,
    output logic   wrap
);

    localparam int TOTAL = ACTIVE_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN;

    // Last position of each phase.
    localparam coord_t LAST_ACTIVE = coord_t'(ACTIVE_LEN - 1);
    localparam coord_t LAST_FRONT  = coord_t'(ACTIVE_LEN + FRONT_LEN - 1);
    localparam coord_t LAST_SYNC   = coord_t'(ACTIVE_LEN + FRONT_LEN + SYNC_LEN - 1);
    localparam coord_t LAST_BACK   = coord_t'(TOTAL - 1);

    // A zero-length phase would make two boundaries coincide; a total above
    // 4096 cannot be held in a 12-bit position.
    generate
        if (ACTIVE_LEN < 1 || FRONT_LEN < 1 || SYNC_LEN < 1 || BACK_LEN < 1) begin : g_bad_len
            $error("painterengine_gpu_timing_axis: every phase length must be at least 1");
        end
        if (TOTAL > COORD_MAX_TOTAL) begin : g_bad_total
            $error("painterengine_gpu_timing_axis: total length exceeds 4096");
        end
    endgenerate

    phase_t phase_r;
    phase_t phase_s;
    coord_t count_r;
    coord_t count_s;

    // State register: phase and position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_r <= PH_ACTIVE;
            count_r <= 12'd0;
        end else begin
            phase_r <= phase_s;
            count_r <= count_s;
        end
    end

    // Next state: clear, step, or hold; phase changes on its last position.
    always_comb begin
        phase_s = phase_r;
        count_s = count_r;
        if (clear) begin
            phase_s = PH_ACTIVE;
            count_s = 12'd0;
        end else if (advance) begin
            if (count_r == LAST_BACK) begin
                count_s = 12'd0;
            end else begin
                count_s = count_r + 12'd1;
            end
            case (phase_r)
                PH_ACTIVE: begin
                    if (count_r == LAST_ACTIVE) phase_s = PH_FRONT;
                    else                        phase_s = PH_ACTIVE;
                end
                PH_FRONT: begin
                    if (count_r == LAST_FRONT) phase_s = PH_SYNC;
                    else                       phase_s = PH_FRONT;
                end
                PH_SYNC: begin
                    if (count_r == LAST_SYNC) phase_s = PH_BACK;
                    else                      phase_s = PH_SYNC;
                end
                PH_BACK: begin
                    if (count_r == LAST_BACK) phase_s = PH_ACTIVE;
                    else                      phase_s = PH_BACK;
                end
                default: phase_s = PH_ACTIVE;
            endcase
        end else begin
            phase_s = phase_r;
            count_s = count_r;
        end
    end

    // Outputs: current position/phase and the wrap strobe of this step.
    always_comb begin
        count = count_r;
        phase = phase_r;
        wrap  = advance && !clear && (phase_r == PH_BACK) && (count_r == LAST_BACK);
    end

endmodule

// File: rtl/painterengine_gpu_video_timing.sv
// painterengine_gpu_video_timing
// Video timing generator on the 5x pixel clock. Each pixel strobe shows the
// current (h, v) position on the registered outputs and then advances h; v
// advances when h wraps. A strobe that samples enable=0 parks the counters at
// (0,0) and drives idle outputs.
// Optional feature macro: VTG_TEST_PATTERN_EN (colour bars on o_wire_rgb).
module painterengine_gpu_video_timing
    import painterengine_gpu_video_pkg::*;
#(
    parameter int   H_ACTIVE  = DEF_H_ACTIVE,
    parameter int   H_FP      = DEF_H_FP,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BP      = DEF_H_BP,
    parameter int   V_ACTIVE  = DEF_V_ACTIVE,
    parameter int   V_FP      = DEF_V_FP,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BP      = DEF_V_BP,
    parameter logic HSYNC_POL = DEF_HSYNC_POL,
    parameter logic VSYNC_POL = DEF_VSYNC_POL
) (
    input  logic        i_wire_5x_pixel_clock,
    input  logic        i_wire_reset,
    input  logic        i_wire_pixel_clock,
    input  logic        i_wire_enable,
    output logic        o_wire_hsync,
    output logic        o_wire_vsync,
    output logic        o_wire_de,
    output logic [11:0] o_wire_x,
    output logic [11:0] o_wire_y,
    output logic        o_wire_line_start,
    output logic        o_wire_frame_start,
    output logic [23:0] o_wire_rgb
);

    logic clk;
    logic rst;
    assign clk = i_wire_5x_pixel_clock;
    assign rst = i_wire_reset;

    logic   step_s;
    logic   park_s;
    coord_t h_count;
    phase_t h_phase;
    logic   h_wrap;
    coord_t v_count;
    phase_t v_phase;
    logic   unused_v_wrap_s;

    assign step_s = i_wire_pixel_clock && i_wire_enable;
    assign park_s = i_wire_pixel_clock && !i_wire_enable;

    painterengine_gpu_timing_axis #(
        .ACTIVE_LEN (H_ACTIVE),
        .FRONT_LEN  (H_FP),
        .SYNC_LEN   (H_SYNC),
        .BACK_LEN   (H_BP)
    ) u_h_axis (
        .clk     (clk),
        .rst     (rst),
        .clear   (park_s),
        .advance (step_s),
        .count   (h_count),
        .phase   (h_phase),
        .wrap    (h_wrap)
    );

    painterengine_gpu_timing_axis #(
        .ACTIVE_LEN (V_ACTIVE),
        .FRONT_LEN  (V_FP),
        .SYNC_LEN   (V_SYNC),
        .BACK_LEN   (V_BP)
    ) u_v_axis (
        .clk     (clk),
        .rst     (rst),
        .clear   (park_s),
        .advance (h_wrap),
        .count   (v_count),
        .phase   (v_phase),
        .wrap    (unused_v_wrap_s)
    );

    logic active_s;
    logic hsync_s;
    logic vsync_s;
    logic line_start_s;
    logic frame_start_s;

    // Output values for the position about to be shown.
    always_comb begin
        active_s      = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
        hsync_s       = (h_phase == PH_SYNC) ? HSYNC_POL : ~HSYNC_POL;
        vsync_s       = (v_phase == PH_SYNC) ? VSYNC_POL : ~VSYNC_POL;
        line_start_s  = (h_count == 12'd0);
        frame_start_s = (h_count == 12'd0) && (v_count == 12'd0);
    end

    logic        hsync_r;
    logic        vsync_r;
    logic        de_r;
    logic [11:0] x_r;
    logic [11:0] y_r;
    logic        line_start_r;
    logic        frame_start_r;

    // Output register: load on an enabled strobe, idle on a disabled strobe,
    // otherwise hold levels and drop the pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_r       <= ~HSYNC_POL;
            vsync_r       <= ~VSYNC_POL;
            de_r          <= 1'b0;
            x_r           <= 12'd0;
            y_r           <= 12'd0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else if (park_s) begin
            hsync_r       <= ~HSYNC_POL;
            vsync_r       <= ~VSYNC_POL;
            de_r          <= 1'b0;
            x_r           <= 12'd0;
            y_r           <= 12'd0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else if (step_s) begin
            hsync_r       <= hsync_s;
            vsync_r       <= vsync_s;
            de_r          <= active_s;
            line_start_r  <= line_start_s;
            frame_start_r <= frame_start_s;
            if (active_s) begin
                x_r <= h_count;
                y_r <= v_count;
            end else begin
                x_r <= x_r;
                y_r <= y_r;
            end
        end else begin
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end
    end

    assign o_wire_hsync       = hsync_r;
    assign o_wire_vsync       = vsync_r;
    assign o_wire_de          = de_r;
    assign o_wire_x           = x_r;
    assign o_wire_y           = y_r;
    assign o_wire_line_start  = line_start_r;
    assign o_wire_frame_start = frame_start_r;

`ifdef VTG_TEST_PATTERN_EN
    logic [2:0]  bar_idx_s;
    logic [23:0] rgb_s;
    logic [23:0] rgb_r;

    // Bar colour of the column about to be shown; black during blanking.
    always_comb begin
        bar_idx_s = 3'((int'(h_count) * 32'sd8) / H_ACTIVE);
        if (active_s) begin
            rgb_s = bar_colour(bar_idx_s);
        end else begin
            rgb_s = 24'h000000;
        end
    end

    // Pixel colour register, same timing as de.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_r <= 24'h000000;
        end else if (park_s) begin
            rgb_r <= 24'h000000;
        end else if (step_s) begin
            rgb_r <= rgb_s;
        end else begin
            rgb_r <= rgb_r;
        end
    end

    assign o_wire_rgb = rgb_r;
`else
    assign o_wire_rgb = 24'h000000;
`endif

endmodule

// File: tb/tb_painterengine_gpu_video_timing.sv
// Bench for painterengine_gpu_video_timing with a tiny 8/2/3/2 x 4/1/2/1
// raster. A position-based reference model (plain h/v integers and range
// tests) predicts every output on every clock.
module tb_painterengine_gpu_video_timing;

    localparam int HA = 8;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 2;
    localparam int VA = 4;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int HT = HA + HF + HS + HB;  // 15
    localparam int VT = VA + VF + VS + VB;  // 8

    localparam logic [52:0] RESET_VEC = {1'b1, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 24'd0};
`ifdef VTG_TEST_PATTERN_EN
    localparam logic [23:0] RGB_X0 = 24'hFFFFFF;
`else
    localparam logic [23:0] RGB_X0 = 24'h000000;
`endif

    logic        clk;
    logic        rst;
    logic        strobe;
    logic        enable;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [11:0] x;
    logic [11:0] y;
    logic        line_start;
    logic        frame_start;
    logic [23:0] rgb;

    int vectors;
    int miscompares;

    // reference model state
    int          m_h;
    int          m_v;
    logic        m_hs;
    logic        m_vs;
    logic        m_de;
    logic [11:0] m_x;
    logic [11:0] m_y;
    logic        m_ls;
    logic        m_fs;
    logic [23:0] m_rgb;
    logic [23:0] colours [8];

    painterengine_gpu_video_timing #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .HSYNC_POL (1'b0), .VSYNC_POL (1'b0)
    ) dut (
        .i_wire_5x_pixel_clock (clk),
        .i_wire_reset          (rst),
        .i_wire_pixel_clock    (strobe),
        .i_wire_enable         (enable),
        .o_wire_hsync          (hsync),
        .o_wire_vsync          (vsync),
        .o_wire_de             (de),
        .o_wire_x              (x),
        .o_wire_y              (y),
        .o_wire_line_start     (line_start),
        .o_wire_frame_start    (frame_start),
        .o_wire_rgb            (rgb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [52:0] dut_vec();
        return {hsync, vsync, de, x, y, line_start, frame_start, rgb};
    endfunction

    function automatic logic [52:0] exp_vec();
        return {m_hs, m_vs, m_de, m_x, m_y, m_ls, m_fs, m_rgb};
    endfunction

    task automatic model_idle();
        m_h = 0; m_v = 0;
        m_hs = 1'b1; m_vs = 1'b1; m_de = 1'b0;
        m_x = 12'd0; m_y = 12'd0;
        m_ls = 1'b0; m_fs = 1'b0; m_rgb = 24'd0;
    endtask

    // One clock of the raster as described: show position, then move on.
    task automatic model_clock(input logic stb, input logic en, input logic rs);
        if (rs || (stb && !en)) begin
            model_idle();
        end else if (stb) begin
            m_de = (m_h < HA) && (m_v < VA);
            m_hs = !((m_h >= HA + HF) && (m_h < HA + HF + HS));
            m_vs = !((m_v >= VA + VF) && (m_v < VA + VF + VS));
            if (m_de) begin
                m_x = 12'(m_h);
                m_y = 12'(m_v);
            end
            m_ls = (m_h == 0);
            m_fs = (m_h == 0) && (m_v == 0);
`ifdef VTG_TEST_PATTERN_EN
            m_rgb = m_de ? colours[(m_h * 8) / HA] : 24'd0;
`else
            m_rgb = 24'd0;
`endif
            m_h = m_h + 1;
            if (m_h == HT) begin
                m_h = 0;
                m_v = (m_v + 1) % VT;
            end
        end else begin
            m_ls = 1'b0;
            m_fs = 1'b0;
        end
    endtask

    // Drive inputs, let one active edge pass, then settle away from it.
    task automatic step(input logic stb, input logic en);
        strobe = stb;
        enable = en;
        @(posedge clk);
        model_clock(stb, en, rst);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; strobe = 1'b0; enable = 1'b0;
        model_idle();
        for (int c = 0; c < 4; c++) begin
            step((c == 2), 1'b1);
            vectors++;
            if (dut_vec() !== RESET_VEC) begin
                miscompares++;
                $display("FAIL reset c%0d: got %h required %h", c, dut_vec(), RESET_VEC);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_first_frame();
        for (int c = 0; c < 40; c++) begin
            step((c % 5) == 4, 1'b1);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL first_frame c%0d: got %h required %h", c, dut_vec(), exp_vec());
            end
            if (c == 4) begin
                vectors++;
                if ({frame_start, de, x, y, rgb} !== {1'b1, 1'b1, 12'd0, 12'd0, RGB_X0}) begin
                    miscompares++;
                    $display("FAIL first_strobe: got fs=%b de=%b x=%0d y=%0d rgb=%h required 1 1 0 0 %h",
                             frame_start, de, x, y, rgb, RGB_X0);
                end
            end
            if (c == 39) begin
                vectors++;
                if ({de, x, rgb} !== {1'b1, 12'd7, 24'd0}) begin
                    miscompares++;
                    $display("FAIL eighth_strobe: got de=%b x=%0d rgb=%h required 1 7 000000", de, x, rgb);
                end
            end
        end
    endtask

    task automatic test_line_timing();
        int ls_cnt = 0;
        int hs_low = 0;
        for (int c = 0; c < 150; c++) begin
            step((c % 5) == 4, 1'b1);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL line c%0d: got %h required %h", c, dut_vec(), exp_vec());
            end
            if ((c % 5) == 4) begin
                if (line_start) ls_cnt++;
                if (!hsync) hs_low++;
                if (!de) begin
                    vectors++;
                    if (rgb !== 24'd0) begin
                        miscompares++;
                        $display("FAIL blank_rgb c%0d: got %h required 000000", c, rgb);
                    end
                end
            end
        end
        vectors++;
        if (ls_cnt !== 2 || hs_low !== 6) begin
            miscompares++;
            $display("FAIL line_counts: got line_starts=%0d hsync_low=%0d required 2 6", ls_cnt, hs_low);
        end
    endtask

    task automatic test_frame_timing();
        int fs_cnt = 0;
        int vs_low = 0;
        int first_fs = -1;
        int interval = 0;
        for (int s = 0; s < 240; s++) begin
            for (int c = 0; c < 5; c++) begin
                step(c == 4, 1'b1);
                vectors++;
                if (dut_vec() !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL frame s%0d c%0d: got %h required %h", s, c, dut_vec(), exp_vec());
                end
            end
            if (frame_start) begin
                fs_cnt++;
                if (first_fs < 0) first_fs = s;
                else interval = s - first_fs;
            end
            if (!vsync) vs_low++;
        end
        vectors++;
        if (fs_cnt !== 2 || interval !== 120 || vs_low !== 60) begin
            miscompares++;
            $display("FAIL frame_counts: got fs=%0d interval=%0d vsync_low=%0d required 2 120 60",
                     fs_cnt, interval, vs_low);
        end
    endtask

    task automatic test_enable_drop();
        int guard = 0;
        while ((m_h != 3 || m_v != 2) && guard < 130) begin
            for (int c = 0; c < 5; c++) step(c == 4, 1'b1);
            guard++;
        end
        vectors++;
        if (guard >= 130) begin
            miscompares++;
            $display("FAIL drop_seek: got no (3,2) within %0d strobes required reach", guard);
        end
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 5; c++) step(c == 4, 1'b0);
            vectors++;
            if (dut_vec() !== RESET_VEC || exp_vec() !== RESET_VEC) begin
                miscompares++;
                $display("FAIL drop_idle s%0d: got %h required %h", s, dut_vec(), RESET_VEC);
            end
        end
        for (int s = 0; s < 20; s++) begin
            for (int c = 0; c < 5; c++) step(c == 4, 1'b1);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL reenable s%0d: got %h required %h", s, dut_vec(), exp_vec());
            end
            if (s == 0) begin
                vectors++;
                if ({de, x, y, line_start, frame_start} !== {1'b1, 12'd0, 12'd0, 1'b1, 1'b1}) begin
                    miscompares++;
                    $display("FAIL restart: got de=%b x=%0d y=%0d ls=%b fs=%b required 1 0 0 1 1",
                             de, x, y, line_start, frame_start);
                end
            end
        end
    endtask

    task automatic test_enable_glitch();
        for (int c = 0; c < 300; c++) begin
            if ((c % 5) == 4) step(1'b1, 1'b1);
            else step(1'b0, 1'($urandom_range(0, 1)));
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL glitch c%0d: got %h required %h", c, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_back_to_back();
        int ls_cnt = 0;
        for (int c = 0; c < 45; c++) begin
            step(1'b1, 1'b1);
            if (line_start) ls_cnt++;
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL b2b c%0d: got %h required %h", c, dut_vec(), exp_vec());
            end
        end
        vectors++;
        if (ls_cnt !== 3) begin
            miscompares++;
            $display("FAIL b2b_lines: got %0d line_starts required 3", ls_cnt);
        end
    endtask

    task automatic test_reset_midline();
        int guard = 0;
        while (m_hs !== 1'b0 && guard < 40) begin
            for (int c = 0; c < 5; c++) step(c == 4, 1'b1);
            guard++;
        end
        vectors++;
        if (hsync !== 1'b0) begin
            miscompares++;
            $display("FAIL midline_sync: got hsync=%b required 0", hsync);
        end
        #3;
        rst = 1'b1;
        model_idle();
        #1;
        vectors++;
        if (dut_vec() !== RESET_VEC) begin
            miscompares++;
            $display("FAIL async_reset: got %h required %h", dut_vec(), RESET_VEC);
        end
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        rst = 1'b0;
        for (int c = 0; c < 25; c++) begin
            step((c % 5) == 4, 1'b1);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL post_reset c%0d: got %h required %h", c, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 59) != 0));
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random c%0d: got %h required %h", c, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        colours[0] = 24'hFFFFFF; colours[1] = 24'hFFFF00;
        colours[2] = 24'h00FFFF; colours[3] = 24'h00FF00;
        colours[4] = 24'hFF00FF; colours[5] = 24'hFF0000;
        colours[6] = 24'h0000FF; colours[7] = 24'h000000;
        test_reset();
        test_first_frame();
        test_line_timing();
        test_frame_timing();
        test_enable_drop();
        test_enable_glitch();
        test_back_to_back();
        test_reset_midline();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
